rr_priority_arbiter: RTL and testbench

//  Parametrised, registered N-input arbiter; next generation of the channel's

---
 rtl/rr_priority_arbiter.sv | 108 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Registered N-input arbiter, fixed MSB-first or round-robin order,
// presenting the winner as index plus one-hot behind valid/ready.
module rr_priority_arbiter #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         any_req
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;
  logic [W-1:0] start;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         accept;

  assign any_req = |req;
  assign accept  = (state_q == GRANT) && grant_ready;

  // Pointer steps below the accepted index, wrapping modulo N.
  assign ptr_d = !accept       ? ptr_q :
                 (idx_q == '0) ? LAST  :
                 idx_q - W'(1);

  // Back-to-back search already sees the post-accept pointer.
  assign start = mode ? ptr_d : LAST;

  always_comb begin
    int p;
    logic [N-1:0] rsh;
    win_found = 1'b0;
    win_idx   = '0;
    p         = 0;
    rsh       = '0;
    for (int i = 0; i < N; i++) begin
      p = int'(start) - i;
      if (p < 0) p = p + N;
      rsh = req >> p;
      if (!win_found && rsh[0]) begin
        win_found = 1'b1;
        win_idx   = W'(p);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          oh_d    = ONE << win_idx;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          if (win_found) begin
            idx_d = win_idx;
            oh_d  = ONE << win_idx;
          end else begin
            state_d = IDLE;
            oh_d    = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= LAST;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_idx    = idx_q;
  assign grant_onehot = oh_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter, N=8 and N=5 instances.
// Inputs change at posedge+1, outputs are sampled at posedge+1.
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req8 = '0;
  logic       mode8 = 1'b0;
  logic       rdy8 = 1'b0;
  logic       vld8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic       any8;

  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0;
  logic       rdy5 = 1'b0;
  logic       vld5;
  logic [2:0] idx5;
  logic [4:0] oh5;
  logic       any5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req8),
    .mode         (mode8),
    .grant_ready  (rdy8),
    .grant_valid  (vld8),
    .grant_idx    (idx8),
    .grant_onehot (oh8),
    .any_req      (any8)
  );

  rr_priority_arbiter #(.N(5)) u_dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req5),
    .mode         (mode5),
    .grant_ready  (rdy5),
    .grant_valid  (vld5),
    .grant_idx    (idx5),
    .grant_onehot (oh5),
    .any_req      (any5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req8 = '0; mode8 = 0; rdy8 = 0;
    req5 = '0; mode5 = 0; rdy5 = 0;
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (vld8 !== 1'b0 || idx8 !== 3'd0 || oh8 !== 8'h00) begin
      errors++;
      $display("FAIL reset8: vld=%b idx=%0d oh=%h, want 0 0 00",
               vld8, idx8, oh8);
    end
    checks++;
    if (vld5 !== 1'b0 || idx5 !== 3'd0 || oh5 !== 5'h00) begin
      errors++;
      $display("FAIL reset5: vld=%b idx=%0d oh=%h, want 0 0 00",
               vld5, idx5, oh5);
    end
    do_reset();
  endtask

  task automatic test_fixed();
    do_reset();
    mode8 = 0; rdy8 = 1; req8 = 8'h90;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (vld8 !== 1'b1 || idx8 !== 3'd7 || oh8 !== 8'h80) begin
        errors++;
        $display("FAIL fixed c%0d: vld=%b idx=%0d oh=%h, want 1 7 80",
                 c, vld8, idx8, oh8);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    logic [7:0] exp_oh;
    do_reset();
    mode8 = 1; rdy8 = 1; req8 = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      step();
      exp_oh = 8'h01 << exp_seq[c];
      checks++;
      if (vld8 !== 1'b1 || idx8 !== 3'(exp_seq[c]) || oh8 !== exp_oh) begin
        errors++;
        $display("FAIL rr c%0d: vld=%b idx=%0d oh=%h, want 1 %0d %h",
                 c, vld8, idx8, oh8, exp_seq[c], exp_oh);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode8 = 1; rdy8 = 0; req8 = 8'h0C;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 2) begin
        req8  = 8'h04;
        mode8 = 0;
      end
      checks++;
      if (vld8 !== 1'b1 || idx8 !== 3'd3 || oh8 !== 8'h08) begin
        errors++;
        $display("FAIL bp_hold c%0d: vld=%b idx=%0d oh=%h, want 1 3 08",
                 c, vld8, idx8, oh8);
      end
    end
    mode8 = 1; rdy8 = 1;
    step();
    checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd2 || oh8 !== 8'h04) begin
      errors++;
      $display("FAIL bp_release: vld=%b idx=%0d oh=%h, want 1 2 04",
               vld8, idx8, oh8);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode8 = 1; rdy8 = 1; req8 = 8'h20;
    step();
    step();
    rdy8 = 0;
    step();
    checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd5) begin
      errors++;
      $display("FAIL rstmid_pre: vld=%b idx=%0d, want 1 5", vld8, idx8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (vld8 !== 1'b0 || oh8 !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_drop: vld=%b oh=%h, want 0 00", vld8, oh8);
    end
    @(negedge clk);
    req8 = 8'hFF; mode8 = 1; rdy8 = 1;
    rst_n = 1'b1;
    step();
    checks++;
    if (vld8 !== 1'b1 || idx8 !== 3'd7 || oh8 !== 8'h80) begin
      errors++;
      $display("FAIL rstmid_first: vld=%b idx=%0d oh=%h, want 1 7 80",
               vld8, idx8, oh8);
    end
  endtask

  task automatic test_nonpow2();
    int exp_seq[6] = '{4, 0, 4, 0, 4, 0};
    logic [4:0] exp_oh;
    do_reset();
    mode5 = 1; rdy5 = 1; req5 = 5'b10001;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_oh = 5'b00001 << exp_seq[c];
      checks++;
      if (vld5 !== 1'b1 || idx5 !== 3'(exp_seq[c]) || oh5 !== exp_oh) begin
        errors++;
        $display("FAIL n5 c%0d: vld=%b idx=%0d oh=%b, want 1 %0d %b",
                 c, vld5, idx5, oh5, exp_seq[c], exp_oh);
      end
    end
    req5 = 5'b11111;
    for (int c = 0; c < 7; c++) begin
      step();
      checks++;
      if (idx5 > 3'd4 || oh5 !== (5'b00001 << idx5)) begin
        errors++;
        $display("FAIL n5_range c%0d: idx=%0d oh=%b, want idx<=4 onehot",
                 c, idx5, oh5);
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    mode8 = 0; req8 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      rdy8 = c[0];
      step();
      checks++;
      if (vld8 !== 1'b0 || any8 !== 1'b0 || oh8 !== 8'h00) begin
        errors++;
        $display("FAIL idle c%0d: vld=%b any=%b oh=%h, want 0 0 00",
                 c, vld8, any8, oh8);
      end
    end
    rdy8 = 0; req8 = 8'h01;
    #1;
    checks++;
    if (any8 !== 1'b1) begin
      errors++;
      $display("FAIL any_req: got %b want 1", any8);
    end
    step();
    req8 = 8'h00;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (vld8 !== 1'b1 || idx8 !== 3'd0 || oh8 !== 8'h01) begin
        errors++;
        $display("FAIL pulse_hold c%0d: vld=%b idx=%0d oh=%h, want 1 0 01",
                 c, vld8, idx8, oh8);
      end
      step();
    end
    rdy8 = 1;
    step();
    checks++;
    if (vld8 !== 1'b0 || oh8 !== 8'h00) begin
      errors++;
      $display("FAIL pulse_done: vld=%b oh=%h, want 0 00", vld8, oh8);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_nonpow2();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
